// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART receiver and transmitter
//
// Purpose: deserialises i_RX_bit into bytes and serialises i_TX_byte onto
// o_TX_bit. Both directions share i_clk and i_rst but are otherwise independent.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-high reset
//   i_RX_bit         serial receive line (asynchronous, idles high)
//   o_Received_byte  last correctly framed byte
//   o_receive_state  one-cycle strobe: o_Received_byte updated
//   o_error          one-cycle strobe: stop bit sampled low
//   i_start          transmit request, honoured only while the transmitter is idle
//   i_TX_byte        byte to send, captured when i_start is accepted
//   o_TX_bit         serial transmit line (idles high)
//   o_transfer_state high while a frame is on the line
//   o_TX_done        one-cycle strobe at the end of the stop bit

module uart_transceiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_LENGTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_RX_bit,
    output logic [DATA_LENGTH-1:0] o_Received_byte,
    output logic                   o_receive_state,
    output logic                   o_error,
    input  logic                   i_start,
    input  logic [DATA_LENGTH-1:0] i_TX_byte,
    output logic                   o_TX_bit,
    output logic                   o_transfer_state,
    output logic                   o_TX_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                   rx_meta;
    logic                   rx_sync;
    state_t                 rx_state,   rx_state_n;
    logic [CNT_W-1:0]       rx_cnt,     rx_cnt_n;
    logic [BIT_W-1:0]       rx_bit_idx, rx_bit_idx_n;
    logic [DATA_LENGTH-1:0] rx_shift,   rx_shift_n;
    logic [DATA_LENGTH-1:0] rx_byte,    rx_byte_n;
    logic                   rx_valid,   rx_valid_n;
    logic                   rx_err,     rx_err_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Synchroniser resets to the idle level so reset never fakes a start bit.
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_meta    <= i_RX_bit;
            rx_sync    <= rx_meta;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit_idx <= rx_bit_idx_n;
            rx_shift   <= rx_shift_n;
            rx_byte    <= rx_byte_n;
            rx_valid   <= rx_valid_n;
            rx_err     <= rx_err_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt;
        rx_bit_idx_n = rx_bit_idx;
        rx_shift_n   = rx_shift;
        rx_byte_n    = rx_byte;
        rx_valid_n   = 1'b0;
        rx_err_n     = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = '0;
                end
            end
            S_START: begin
                // Half a bit in: a line that has gone back high was a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n     = '0;
                    rx_bit_idx_n = '0;
                    rx_state_n   = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_n   = '0;
                    // LSB arrives first, so shift in at the top and move right.
                    rx_shift_n = {rx_sync, rx_shift[DATA_LENGTH-1:1]};
                    if (rx_bit_idx == BIT_LAST) begin
                        rx_state_n = S_STOP;
                    end else begin
                        rx_bit_idx_n = rx_bit_idx + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_IDLE;
                    if (rx_sync) begin
                        rx_byte_n  = rx_shift;
                        rx_valid_n = 1'b1;
                    end else begin
                        rx_err_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    assign o_Received_byte = rx_byte;
    assign o_receive_state = rx_valid;
    assign o_error         = rx_err;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state,   tx_state_n;
    logic [CNT_W-1:0]       tx_cnt,     tx_cnt_n;
    logic [BIT_W-1:0]       tx_bit_idx, tx_bit_idx_n;
    logic [DATA_LENGTH-1:0] tx_shift,   tx_shift_n;
    logic                   tx_line,    tx_line_n;
    logic                   tx_busy,    tx_busy_n;
    logic                   tx_done,    tx_done_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state   <= S_IDLE;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
            tx_line    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_state   <= tx_state_n;
            tx_cnt     <= tx_cnt_n;
            tx_bit_idx <= tx_bit_idx_n;
            tx_shift   <= tx_shift_n;
            tx_line    <= tx_line_n;
            tx_busy    <= tx_busy_n;
            tx_done    <= tx_done_n;
        end
    end

    // The line is registered: each state sets the level of the *next* bit at
    // the edge that ends the current one, so every bit lasts CLKS_PER_BIT cycles.
    always_comb begin
        tx_state_n   = tx_state;
        tx_cnt_n     = tx_cnt;
        tx_bit_idx_n = tx_bit_idx;
        tx_shift_n   = tx_shift;
        tx_line_n    = tx_line;
        tx_busy_n    = tx_busy;
        tx_done_n    = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                if (i_start) begin
                    tx_shift_n = i_TX_byte;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b0;
                    tx_busy_n  = 1'b1;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n     = '0;
                    tx_bit_idx_n = '0;
                    tx_line_n    = tx_shift[0];
                    tx_shift_n   = tx_shift >> 1;
                    tx_state_n   = S_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit_idx == BIT_LAST) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = S_STOP;
                    end else begin
                        tx_bit_idx_n = tx_bit_idx + 1'b1;
                        tx_line_n    = tx_shift[0];
                        tx_shift_n   = tx_shift >> 1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_busy_n  = 1'b0;
                    tx_done_n  = 1'b1;
                    tx_state_n = S_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    assign o_TX_bit         = tx_line;
    assign o_transfer_state = tx_busy;
    assign o_TX_done        = tx_done;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed self-checking bench for uart_transceiver

module tb_uart_transceiver;

    localparam int CPB = 4;
    localparam int DL  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_drv;
    logic          rx_loop;
    logic          start_drv;
    logic          tx_loop;
    logic [DL-1:0] tx_byte;

    logic          rx_line;
    logic          start;
    logic [DL-1:0] rx_byte;
    logic          rx_valid;
    logic          rx_err;
    logic          tx_bit;
    logic          tx_busy;
    logic          tx_done;

    assign rx_line = rx_loop ? tx_bit : rx_drv;
    assign start   = start_drv | (tx_loop & tx_done);

    always #5 clk = ~clk;

    uart_transceiver #(
        .CLKS_PER_BIT (CPB),
        .DATA_LENGTH  (DL)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_RX_bit         (rx_line),
        .o_Received_byte  (rx_byte),
        .o_receive_state  (rx_valid),
        .o_error          (rx_err),
        .i_start          (start),
        .i_TX_byte        (tx_byte),
        .o_TX_bit         (tx_bit),
        .o_transfer_state (tx_busy),
        .o_TX_done        (tx_done)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            rx_pulses = 0;
    int            rx_errs   = 0;
    logic [DL-1:0] rx_q[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_pulses++;
            rx_q.push_back(rx_byte);
        end
        if (rx_err) rx_errs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_pulses = 0;
        rx_errs   = 0;
        rx_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_bit"},  32'(tx_bit),   32'd1);
        check({tag, "_rx_byte"}, 32'(rx_byte),  32'd0);
        check({tag, "_rx_val"},  32'(rx_valid), 32'd0);
        check({tag, "_rx_err"},  32'(rx_err),   32'd0);
        check({tag, "_busy"},    32'(tx_busy),  32'd0);
        check({tag, "_done"},    32'(tx_done),  32'd0);
    endtask

    task automatic send_rx(input logic [DL-1:0] data, input logic stop_bit);
        logic [DL+1:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int i = 0; i < DL + 2; i++) begin
            rx_drv = frame[i];
            repeat (CPB) tick();
        end
        rx_drv = 1'b1;
        repeat (12) tick();
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    logic [9:0] exp_frame;
    logic       ok;
    int         bad;
    int         busy_cycles;
    int         gaps;

    initial begin
        rst       = 1'b1;
        rx_drv    = 1'b1;
        rx_loop   = 1'b0;
        tx_loop   = 1'b0;
        start_drv = 1'b0;
        tx_byte   = '0;

        // 1: reset values
        repeat (3) tick();
        check_reset_values("rst");
        rst = 1'b0;
        tick();

        // 2: good frame 0xA5
        clear_mon();
        send_rx(8'hA5, 1'b1);
        check("rx_a5_pulses", 32'(rx_pulses), 32'd1);
        check("rx_a5_errs",   32'(rx_errs),   32'd0);
        check("rx_a5_byte",   32'(rx_byte),   32'hA5);

        // 3: framing errors keep the last good byte; short glitch is ignored
        clear_mon();
        send_rx(8'hA5, 1'b0);
        send_rx(8'h3C, 1'b0);
        check("ferr_errs",   32'(rx_errs),   32'd2);
        check("ferr_pulses", 32'(rx_pulses), 32'd0);
        check("ferr_byte",   32'(rx_byte),   32'hA5);
        clear_mon();
        rx_drv = 1'b0;
        tick();
        rx_drv = 1'b1;
        repeat (12) tick();
        check("glitch_pulses", 32'(rx_pulses), 32'd0);
        check("glitch_errs",   32'(rx_errs),   32'd0);

        // 4: transmit 0x3C, expected line 0,0,0,1,1,1,1,0,0,1 (first bit at index 0)
        exp_frame   = 10'b1001111000;
        bad         = 0;
        busy_cycles = 0;
        tx_byte     = 8'h3C;
        start_drv   = 1'b1;
        tick();
        start_drv   = 1'b0;
        tx_byte     = 8'hFF;
        for (int c = 0; c < 40; c++) begin
            if (tx_bit !== exp_frame[c / CPB]) bad++;
            if (tx_busy === 1'b1) busy_cycles++;
            start_drv = (c == 10);
            tick();
        end
        start_drv = 1'b0;
        check("tx3c_bits",      32'(bad),         32'd0);
        check("tx3c_busy",      32'(busy_cycles), 32'd40);
        check("tx3c_done",      32'(tx_done),     32'd1);
        check("tx3c_busy_end",  32'(tx_busy),     32'd0);
        check("tx3c_line_end",  32'(tx_bit),      32'd1);
        tick();
        check("tx3c_done_once", 32'(tx_done),     32'd0);
        check("tx3c_no_restart", 32'(tx_busy),    32'd0);

        // 5: 32 back-to-back frames looped onto the receiver
        clear_mon();
        rx_loop   = 1'b1;
        gaps      = 0;
        tx_byte   = 8'h00;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        tx_loop   = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            wait_done(ok);
            check("loop_done", 32'(ok), 32'd1);
            if (!ok) break;
            if (k < 32) tx_byte = 8'(k);
            else tx_loop = 1'b0;
            tick();
            if (k < 32 && tx_busy !== 1'b1) gaps++;
        end
        repeat (20) tick();
        check("loop_gaps",  32'(gaps),        32'd0);
        check("loop_count", 32'(rx_q.size()), 32'd32);
        check("loop_errs",  32'(rx_errs),     32'd0);
        for (int i = 0; i < rx_q.size() && i < 32; i++) begin
            check("loop_byte", 32'(rx_q[i]), 32'(i));
        end

        // 6: reset while both directions are mid-DATA, then a fresh frame
        tx_byte   = 8'hC3;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        tick();
        check("midrst_line_high", 32'(tx_bit), 32'd1);
        clear_mon();
        tx_byte   = 8'h96;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        wait_done(ok);
        check("fresh_done", 32'(ok), 32'd1);
        repeat (20) tick();
        check("fresh_pulses", 32'(rx_pulses), 32'd1);
        check("fresh_errs",   32'(rx_errs),   32'd0);
        check("fresh_byte",   32'(rx_byte),   32'h96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
